// File: rtl/ntm_adder_arbiter.sv
// ntm_adder_arbiter
// Round-robin controller sharing one registered adder among NUM_REQ requesters.
// Accepted operand pairs are registered onto the adder inputs. The requester ID
// travels down a tag pipeline that is aligned with the adder latency. Each sum is
// captured together with its tag into an in-order result FIFO. Issue is
// credit-limited, so every result already in flight is guaranteed a FIFO slot.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  per-requester request strobe
//   req_ready  per-requester grant (one-hot or zero, combinational)
//   req_in1    packed first operands, requester i uses slice i
//   req_in2    packed second operands
//   add_in1    registered adder operand 1 (holds when idle)
//   add_in2    registered adder operand 2 (holds when idle)
//   add_valid  operation presented to the adder this cycle
//   add_out    adder sum, valid ADD_LATENCY cycles after add_valid
//   rsp_valid  result FIFO head valid
//   rsp_ready  consumer accepts the head
//   rsp_id     requester ID of the head result
//   rsp_data   sum of the head result
module ntm_adder_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADD_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in2,
  output logic [DATA_WIDTH-1:0]         add_in1,
  output logic [DATA_WIDTH-1:0]         add_in2,
  output logic                          add_valid,
  input  logic [DATA_WIDTH:0]           add_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH:0]           rsp_data
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  // Arbitration and issue
  logic                  en_r;
  logic [IDW-1:0]        ptr_r;
  logic [IDW-1:0]        sel_s;
  logic [IDW-1:0]        cand_s;
  logic                  hit_s;
  logic [NUM_REQ-1:0]    onehot_s;
  logic                  credit_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] in1_arr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] in2_arr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] add_in1_r;
  logic [DATA_WIDTH-1:0] add_in2_r;
  logic                  add_valid_r;
  logic [IDW-1:0]        add_id_r;

  // Tag pipeline, one stage per adder latency cycle
  logic                  pipe_vld_r [ADD_LATENCY];
  logic [IDW-1:0]        pipe_tag_r [ADD_LATENCY];

  // Result FIFO and credit bookkeeping
  logic [DATA_WIDTH:0]   mem_data_r [FIFO_DEPTH];
  logic [IDW-1:0]        mem_id_r   [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         fifo_cnt_r;
  logic [CW-1:0]         in_flight_r;
  logic                  push_s;
  logic                  pop_s;

  // Unpack the operand buses into per-requester arrays
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in1_arr_s[i] = req_in1[i*DATA_WIDTH +: DATA_WIDTH];
      in2_arr_s[i] = req_in2[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search from ptr_r; scanning offsets downwards lets the lowest
  // offset with a valid request win the last assignment
  always_comb begin
    sel_s  = ptr_r;
    cand_s = ptr_r;
    hit_s  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = ptr_r + IDW'(k);
      sel_s  = req_valid[cand_s] ? cand_s : sel_s;
      hit_s  = hit_s | req_valid[cand_s];
    end
  end

  // Credit uses registered counts only, so a pop frees a slot one cycle later
  always_comb begin
    credit_s = (({1'b0, in_flight_r} + {1'b0, fifo_cnt_r}) < (CW+1)'(FIFO_DEPTH));
    accept_s = hit_s & credit_s & en_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot_s[i] = (sel_s == IDW'(i));
    end
    req_ready = onehot_s & {NUM_REQ{accept_s}};
  end

  // Grant enable: keeps req_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r <= 1'b0;
    end else begin
      en_r <= 1'b1;
    end
  end

  // Priority pointer moves past the granted requester, holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {IDW{1'b0}};
    end else if (accept_s) begin
      ptr_r <= sel_s + IDW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Issue stage: operands and ID captured on accept, valid pulses one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_in1_r   <= {DATA_WIDTH{1'b0}};
      add_in2_r   <= {DATA_WIDTH{1'b0}};
      add_id_r    <= {IDW{1'b0}};
      add_valid_r <= 1'b0;
    end else if (accept_s) begin
      add_in1_r   <= in1_arr_s[sel_s];
      add_in2_r   <= in2_arr_s[sel_s];
      add_id_r    <= sel_s;
      add_valid_r <= 1'b1;
    end else begin
      add_in1_r   <= add_in1_r;
      add_in2_r   <= add_in2_r;
      add_id_r    <= add_id_r;
      add_valid_r <= 1'b0;
    end
  end

  // Tag pipeline follows add_valid so the last stage lines up with add_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ADD_LATENCY; k++) begin
        pipe_vld_r[k] <= 1'b0;
        pipe_tag_r[k] <= {IDW{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= add_valid_r;
      pipe_tag_r[0] <= add_id_r;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        pipe_tag_r[k] <= pipe_tag_r[k-1];
      end
    end
  end

  always_comb begin
    push_s = pipe_vld_r[ADD_LATENCY-1];
    pop_s  = rsp_valid & rsp_ready;
  end

  // FIFO storage and pointers; storage is cleared so the head reads zero in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i] <= {(DATA_WIDTH+1){1'b0}};
        mem_id_r[i]   <= {IDW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= add_out;
        mem_id_r[wr_ptr_r]   <= pipe_tag_r[ADD_LATENCY-1];
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy and in-flight counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cnt_r  <= {CW{1'b0}};
      in_flight_r <= {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      case ({accept_s, push_s})
        2'b10:   in_flight_r <= in_flight_r + CW'(1);
        2'b01:   in_flight_r <= in_flight_r - CW'(1);
        default: in_flight_r <= in_flight_r;
      endcase
    end
  end

  assign add_in1   = add_in1_r;
  assign add_in2   = add_in2_r;
  assign add_valid = add_valid_r;
  assign rsp_valid = (fifo_cnt_r != {CW{1'b0}});
  assign rsp_id    = mem_id_r[rd_ptr_r];
  assign rsp_data  = mem_data_r[rd_ptr_r];

endmodule

// File: tb/tb_ntm_adder_arbiter.sv
// Directed bench for ntm_adder_arbiter with a behavioural registered adder.
module tb_ntm_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_in1;
  logic [31:0] req_in2;
  logic [7:0]  add_in1;
  logic [7:0]  add_in2;
  logic        add_valid;
  logic [8:0]  add_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  e_rr;
    logic        e_av;
    logic [7:0]  e_a1;
    logic [7:0]  e_a2;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [8:0]  e_dat;
  } vec_t;

  vec_t vt [16];

  ntm_adder_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADD_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .add_in1(add_in1), .add_in2(add_in2), .add_valid(add_valid),
    .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // One-cycle registered adder
  always @(posedge clk or negedge rst) begin
    if (!rst) add_out <= 9'd0;
    else      add_out <= {1'b0, add_in1} + {1'b0, add_in2};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] rv, input logic [31:0] in1,
                      input logic [31:0] in2, input logic [3:0] e_rr, input logic e_av,
                      input logic [7:0] e_a1, input logic [7:0] e_a2, input logic e_rv,
                      input logic [1:0] e_id, input logic [8:0] e_dat);
    vt[i].rv = rv;     vt[i].in1 = in1;   vt[i].in2 = in2;
    vt[i].e_rr = e_rr; vt[i].e_av = e_av; vt[i].e_a1 = e_a1; vt[i].e_a2 = e_a2;
    vt[i].e_rv = e_rv; vt[i].e_id = e_id; vt[i].e_dat = e_dat;
  endtask

  function automatic logic [7:0] f1(input int k);
    return 8'((k * 37 + 11) % 256);
  endfunction

  function automatic logic [7:0] f2(input int k);
    return 8'((k * 91 + 200) % 256);
  endfunction

  localparam logic [31:0] SG1 = 32'h0000_0005, SG2 = 32'h0000_0002;
  localparam logic [31:0] CY  = 32'h00FF_0000;
  localparam logic [31:0] FR1 = 32'h281E_140A, FR2 = 32'h0403_0201;

  initial begin
    logic [7:0]  op1 [4];
    logic [7:0]  op2 [4];
    int          nextk [4];
    int          k_grant;
    int          k_pop;
    int          g;
    logic [3:0]  e_rr;
    logic        e_v;
    logic [1:0]  e_id;
    logic [8:0]  e_dat;

    // single request, carry, then all four requesters (pointer at 3)
    setv( 0, 4'b0001, SG1, SG2, 4'b0001, 1'b0,   0,   0, 1'b0, 2'd0,   0);
    setv( 1, 4'b0000, SG1, SG2, 4'b0000, 1'b1,   5,   2, 1'b0, 2'd0,   0);
    setv( 2, 4'b0000, SG1, SG2, 4'b0000, 1'b0,   5,   2, 1'b0, 2'd0,   0);
    setv( 3, 4'b0000, SG1, SG2, 4'b0000, 1'b0,   5,   2, 1'b1, 2'd0,   7);
    setv( 4, 4'b0100, CY,  CY,  4'b0100, 1'b0,   5,   2, 1'b0, 2'd0,   0);
    setv( 5, 4'b0000, CY,  CY,  4'b0000, 1'b1, 255, 255, 1'b0, 2'd0,   0);
    setv( 6, 4'b0000, CY,  CY,  4'b0000, 1'b0, 255, 255, 1'b0, 2'd0,   0);
    setv( 7, 4'b0000, CY,  CY,  4'b0000, 1'b0, 255, 255, 1'b1, 2'd2, 510);
    setv( 8, 4'b1111, FR1, FR2, 4'b1000, 1'b0, 255, 255, 1'b0, 2'd0,   0);
    setv( 9, 4'b1111, FR1, FR2, 4'b0001, 1'b1,  40,   4, 1'b0, 2'd0,   0);
    setv(10, 4'b1111, FR1, FR2, 4'b0010, 1'b1,  10,   1, 1'b0, 2'd0,   0);
    setv(11, 4'b1111, FR1, FR2, 4'b0100, 1'b1,  20,   2, 1'b1, 2'd3,  44);
    setv(12, 4'b0000, FR1, FR2, 4'b0000, 1'b1,  30,   3, 1'b1, 2'd0,  11);
    setv(13, 4'b0000, FR1, FR2, 4'b0000, 1'b0,  30,   3, 1'b1, 2'd1,  22);
    setv(14, 4'b0000, FR1, FR2, 4'b0000, 1'b0,  30,   3, 1'b1, 2'd2,  33);
    setv(15, 4'b0000, FR1, FR2, 4'b0000, 1'b0,  30,   3, 1'b0, 2'd0,   0);

    // reset state, with requests already asserted
    rst = 1'b0; req_valid = 4'hF; req_in1 = FR1; req_in2 = FR2; rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_in1", add_in1, 0);
    chk("rst_add_in2", add_in2, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    // table-driven section
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = vt[i].rv; req_in1 = vt[i].in1; req_in2 = vt[i].in2; rsp_ready = 1'b1;
      #1;
      chk("tbl_req_ready", req_ready, vt[i].e_rr);
      chk("tbl_add_valid", add_valid, vt[i].e_av);
      chk("tbl_add_in1", add_in1, vt[i].e_a1);
      chk("tbl_add_in2", add_in2, vt[i].e_a2);
      chk("tbl_rsp_valid", rsp_valid, vt[i].e_rv);
      if (vt[i].e_rv) begin
        chk("tbl_rsp_id", rsp_id, vt[i].e_id);
        chk("tbl_rsp_data", rsp_data, vt[i].e_dat);
      end
    end

    // backpressure: pointer at 3, four grants then stall until a pop
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req_valid = (c < 10) ? 4'hF : 4'h0;
      rsp_ready = (c >= 8);
      req_in1 = FR1; req_in2 = FR2;
      #1;
      if (c < 4)       e_rr = 4'b0001 << ((3 + c) % 4);
      else if (c == 9) e_rr = 4'b1000;
      else             e_rr = 4'b0000;
      e_v = (c >= 3) && (c <= 12);
      case (c)
        9:       begin e_id = 2'd0; e_dat = 9'd11; end
        10:      begin e_id = 2'd1; e_dat = 9'd22; end
        11:      begin e_id = 2'd2; e_dat = 9'd33; end
        default: begin e_id = 2'd3; e_dat = 9'd44; end
      endcase
      chk("bp_req_ready", req_ready, e_rr);
      chk("bp_rsp_valid", rsp_valid, e_v);
      if (e_v) begin
        chk("bp_rsp_id", rsp_id, e_id);
        chk("bp_rsp_data", rsp_data, e_dat);
      end
    end

    // full FIFO with toggling rsp_ready; operands change after every grant
    k_grant = 0; k_pop = 0; g = -1;
    for (int i = 0; i < 4; i++) begin
      nextk[i] = i; op1[i] = f1(i); op2[i] = f2(i);
    end
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (g >= 0) begin
        nextk[g] = nextk[g] + 4;
        op1[g] = f1(nextk[g]); op2[g] = f2(nextk[g]);
        g = -1;
      end
      for (int i = 0; i < 4; i++) begin
        req_in1[i*8 +: 8] = op1[i];
        req_in2[i*8 +: 8] = op2[i];
      end
      req_valid = (cyc < 40) ? 4'hF : 4'h0;
      rsp_ready = (cyc % 2 == 1);
      #1;
      if (rsp_valid && rsp_ready) begin
        chk("full_rsp_id", rsp_id, k_pop % 4);
        chk("full_rsp_data", rsp_data, {1'b0, f1(k_pop)} + {1'b0, f2(k_pop)});
        k_pop++;
      end
      if (req_ready != 4'h0) begin
        chk("full_grant", req_ready, 4'b0001 << (k_grant % 4));
        g = k_grant % 4;
        k_grant++;
      end
      if (cyc >= 40 && k_pop == k_grant && !rsp_valid) break;
    end
    chk("full_drained", k_pop, k_grant);
    chk("full_rate", (k_grant >= 16), 1);

    // reset with three operations outstanding
    @(negedge clk);
    req_valid = 4'hF; req_in1 = 32'h1122_3344; req_in2 = 32'h0101_0101; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_pre_rsp_valid", rsp_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_req_ready", req_ready, 0);
    chk("mid_add_valid", add_valid, 0);
    chk("mid_add_in1", add_in1, 0);
    chk("mid_add_in2", add_in2, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_id", rsp_id, 0);
    chk("mid_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_stale", rsp_valid, 0);
    end
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("post_rst_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("post_rst_add_valid", add_valid, 1);
    chk("post_rst_add_in1", add_in1, 8'h44);
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 1);
    chk("post_rst_rsp_id", rsp_id, 0);
    chk("post_rst_rsp_data", rsp_data, 9'd69);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
